// File: rtl/cla_nibble_serializer_if.sv
// Operand/result handshake and external 4-bit group-adder bus for cla_nibble_serializer.
// The slave modport is the serializer's view; the master modport is the surrounding logic's view.
interface cla_nibble_serializer_if #(
    parameter int unsigned WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;

    logic [3:0]       grp_a;
    logic [3:0]       grp_b;
    logic             grp_cin;
    logic [3:0]       grp_r;
    logic             grp_p;
    logic             grp_g;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    modport slave (
        input  in_valid, in_a, in_b, in_cin,
        input  grp_r, grp_p, grp_g,
        input  out_ready,
        output in_ready,
        output grp_a, grp_b, grp_cin,
        output out_valid, out_sum, out_cout, out_ovf
    );

    modport master (
        output in_valid, in_a, in_b, in_cin,
        output grp_r, grp_p, grp_g,
        output out_ready,
        input  in_ready,
        input  grp_a, grp_b, grp_cin,
        input  out_valid, out_sum, out_cout, out_ovf
    );
endinterface

// File: rtl/cla_nibble_serializer.sv
// Digit-serial WIDTH-bit adder front end: feeds one nibble per cycle to an external
// 4-bit group adder, chains the group carry and reassembles the sum with flags.
module cla_nibble_serializer #(
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    cla_nibble_serializer_if.slave   bus
);
    localparam int unsigned NIBBLES = WIDTH / 4;
    localparam int unsigned IDX_W   = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic             carry_q;
    logic             accept;
    logic             last;

    assign last = (idx_q == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.grp_a     = '0;
        bus.grp_b     = '0;
        bus.grp_cin   = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_sum   = '0;
        bus.out_cout  = 1'b0;
        bus.out_ovf   = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Held low while reset is asserted so no handshake is advertised.
                bus.in_ready = rst_n;
                if (bus.in_valid && rst_n) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                bus.grp_a   = a_q[{idx_q, 2'b00} +: 4];
                bus.grp_b   = b_q[{idx_q, 2'b00} +: 4];
                bus.grp_cin = carry_q;
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                bus.out_sum   = sum_q;
                bus.out_cout  = carry_q;
                // MSB operand bits xor sum bit recover the carry into the MSB.
                bus.out_ovf   = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ sum_q[WIDTH-1] ^ carry_q;
                bus.in_ready  = bus.out_ready;
                if (bus.out_ready) begin
                    state_d = bus.in_valid ? RUN : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        accept = bus.in_valid && bus.in_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else if (accept) begin
            a_q     <= bus.in_a;
            b_q     <= bus.in_b;
            carry_q <= bus.in_cin;
            idx_q   <= '0;
        end else if (state_q == RUN) begin
            sum_q[{idx_q, 2'b00} +: 4] <= bus.grp_r;
            carry_q <= bus.grp_g | (bus.grp_p & carry_q);
            if (!last) begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_cla_nibble_serializer.sv
// Scoreboard bench for cla_nibble_serializer (WIDTH=64) with a behavioural 4-bit group adder.
module tb_cla_nibble_serializer;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    cla_nibble_serializer_if #(.WIDTH(64)) bus ();

    cla_nibble_serializer #(.WIDTH(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural group adder: sum nibble plus group propagate/generate.
    logic [4:0] ab_sum;
    logic [4:0] abc_sum;
    always_comb begin
        ab_sum    = {1'b0, bus.grp_a} + {1'b0, bus.grp_b};
        abc_sum   = ab_sum + {4'b0000, bus.grp_cin};
        bus.grp_r = abc_sum[3:0];
        bus.grp_g = ab_sum[4];
        bus.grp_p = &(bus.grp_a ^ bus.grp_b);
    end

    typedef struct packed {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned pushed = 0;
    int unsigned popped = 0;
    bit          rand_rdy = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input logic cin);
        exp_t        m;
        logic [64:0] s;
        s      = {1'b0, a} + {1'b0, b} + {64'd0, cin};
        m.sum  = s[63:0];
        m.cout = s[64];
        m.ovf  = (a[63] == b[63]) && (s[63] != a[63]);
        return m;
    endfunction

    // Monitor: a result transfers on the next edge whenever valid & ready hold mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_result: got sum %h with no pending operation", bus.out_sum);
                end else begin
                    e = exp_q.pop_front();
                    popped++;
                    check("sum",  bus.out_sum,       e.sum);
                    check("cout", 64'(bus.out_cout), 64'(e.cout));
                    check("ovf",  64'(bus.out_ovf),  64'(e.ovf));
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic cin,
                        input logic [63:0] es, input logic ec, input logic eo,
                        input int unsigned gap);
        exp_t        e;
        int unsigned n;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_cin   = cin;
        bus.in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: in_ready got 0 after %0d cycles, expected 1", n);
        end else begin
            e.sum  = es;
            e.cout = ec;
            e.ovf  = eo;
            exp_q.push_back(e);
            pushed++;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_a     = {$urandom, $urandom};
        bus.in_b     = {$urandom, $urandom};
        bus.in_cin   = 1'($urandom_range(0, 1));
    endtask

    initial begin
        int unsigned n;
        int unsigned ones;
        logic        first;
        logic [63:0] ra, rb;
        logic        rc;
        exp_t        m;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_cin    = 1'b0;
        bus.out_ready = 1'b1;

        #12;
        check("rst_in_ready",  64'(bus.in_ready),  64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_sum",   bus.out_sum,        64'd0);
        check("rst_out_cout",  64'(bus.out_cout),  64'd0);
        check("rst_out_ovf",   64'(bus.out_ovf),   64'd0);
        check("rst_grp_a",     64'(bus.grp_a),     64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_in_ready", 64'(bus.in_ready), 64'd1);

        // All-ones + 1: full carry ripple; latency from accept edge to out_valid.
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0, 0);
        n = 0;
        while (!bus.out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", 64'(n), 64'd16);

        send(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 0);
        send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1, 0);

        // Carry-in only: grp_cin must be set on nibble 0 and nowhere else.
        send(64'h0, 64'h0, 1'b1, 64'h1, 1'b0, 1'b0, 0);
        first = bus.grp_cin;
        ones  = 0;
        for (int i = 0; i < 16; i++) begin
            if (bus.grp_cin) ones++;
            @(posedge clk);
            #1;
        end
        check("grp_cin_nib0",  64'(first), 64'd1);
        check("grp_cin_count", 64'(ones),  64'd1);

        // Back-pressure in DONE, then back-to-back accept on the release edge.
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        send(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0,
             64'h1234_5678_9ABC_DF00, 1'b0, 1'b0, 0);
        n = 0;
        while (!bus.out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", 64'(bus.out_valid), 64'd1);
            check("hold_sum",   bus.out_sum,        64'h1234_5678_9ABC_DF00);
            check("hold_cout",  64'(bus.out_cout),  64'd0);
            check("hold_ready", 64'(bus.in_ready),  64'd0);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        send(64'hFFFF_0000_FFFF_0000, 64'h0001_0000_0001_0000, 1'b0,
             64'h0000_0001_0000_0000, 1'b1, 1'b0, 0);
        check("b2b_in_ready",  64'(bus.in_ready),  64'd0);
        check("b2b_out_valid", 64'(bus.out_valid), 64'd0);

        // Reset during nibble 7 aborts the operation.
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
             64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 0);
        repeat (7) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        pushed--;
        check("abort_out_valid", 64'(bus.out_valid), 64'd0);
        check("abort_in_ready",  64'(bus.in_ready),  64'd0);
        check("abort_out_sum",   bus.out_sum,        64'd0);
        check("abort_grp_a",     64'(bus.grp_a),     64'd0);
        check("abort_grp_cin",   64'(bus.grp_cin),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        send(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0,
             64'h2222_2222_2222_2211, 1'b0, 1'b0, 0);

        // Random operands with random input gaps and consumer back-pressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rc = 1'($urandom_range(0, 1));
            if (i % 17 == 0) ra = 64'hFFFF_FFFF_FFFF_FFFF;
            m = model(ra, rb, rc);
            send(ra, rb, rc, m.sum, m.cout, m.ovf, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
        end
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        rand_rdy = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("drain_pending", 64'(exp_q.size()), 64'd0);
        check("results_count", 64'(popped),       64'(pushed));
        check("idle_at_end",   64'(bus.out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
